// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the hazard/stall control block.
//   hz_state_t : load-use FSM states (run normally / issuing extra bubbles)
//   REG_ZERO   : hard-wired zero register index, never a hazard source
package cpu_pkg;

    typedef enum logic {HZ_RUN, HZ_LU_STALL} hz_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   in  clock
//   reset in  synchronous active-high clear
//   inc   in  count enable
//   q     out current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk)
        if (reset) r_q <= '0;
        else if (inc && r_q != '1) r_q <= r_q + 1'b1;

    assign q = r_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/flush/freeze control for hazards forwarding cannot cover.
//   clk, reset                      clock, synchronous active-high reset
//   ID_EX_MemRead, ID_EX_Rw         load in EX and its destination
//   IF_ID_Ra, IF_ID_Rb, IF_ID_UsesRb sources of the instruction in ID
//   EX_MEM_MemRead, EX_MEM_MemWrite memory access in MEM
//   MemReady                        data memory completes this cycle
//   BrTaken                         taken branch resolved in MEM
//   PCWrite, IF_ID_Write            front-end enables
//   IF_ID_Flush, ID_EX_Bubble       squash IF/ID, inject NOP into ID/EX
//   Pipe_Freeze                     hold ID/EX, EX/MEM, MEM/WB
//   MemTimeout                      sticky: memory stalled TIMEOUT cycles in a row
//   StallCycles, FlushCount         saturating performance counters
module hazard_stall_unit
    import cpu_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LU_STALL = 1,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rw,
    input  logic [REG_W-1:0] IF_ID_Ra,
    input  logic [REG_W-1:0] IF_ID_Rb,
    input  logic             IF_ID_UsesRb,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             MemReady,
    input  logic             BrTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int CW = $clog2(LU_STALL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    hz_state_t     r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [TW-1:0] r_wait, w_wait_nx;
    logic          r_timeout;
    logic          w_busy, w_lu, w_stall, w_stall_inc, w_flush_inc;

    assign w_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~MemReady;
    assign w_lu   = ID_EX_MemRead & (ID_EX_Rw != REG_W'(REG_ZERO)) &
                    ((ID_EX_Rw == IF_ID_Ra) | (IF_ID_UsesRb & (ID_EX_Rw == IF_ID_Rb)));
    // Once in LU_STALL the pending bubbles are issued regardless of lu.
    assign w_stall     = (r_state == HZ_LU_STALL) | w_lu;
    assign w_stall_inc = ~reset & ~w_busy & ~BrTaken & w_stall;
    assign w_flush_inc = ~reset & ~w_busy & BrTaken;

    // Priority reset > busy > branch > stall, folded into each enable.
    always_comb begin
        PCWrite      = (reset | w_busy) ? 1'b0 : (BrTaken | ~w_stall);
        IF_ID_Write  = (reset | w_busy) ? 1'b0 : (BrTaken | ~w_stall);
        IF_ID_Flush  = reset | (~w_busy & BrTaken);
        ID_EX_Bubble = reset | (~w_busy & (BrTaken | w_stall));
        Pipe_Freeze  = ~reset & w_busy;
    end

    // A frozen pipe holds state and bubble count; a branch abandons any stall.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (!w_busy) begin
            if (BrTaken) begin
                w_state_nx = HZ_RUN;
                w_cnt_nx   = '0;
            end else if (r_state == HZ_LU_STALL) begin
                w_cnt_nx   = r_cnt - 1'b1;
                w_state_nx = (r_cnt == CW'(1)) ? HZ_RUN : HZ_LU_STALL;
            end else if (w_lu && LU_STALL > 1) begin
                w_state_nx = HZ_LU_STALL;
                w_cnt_nx   = CW'(LU_STALL - 1);
            end
        end
    end

    assign w_wait_nx = w_busy ? ((r_wait == TW'(TIMEOUT)) ? r_wait : r_wait + 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= HZ_RUN;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_wait    <= w_wait_nx;
            r_timeout <= r_timeout | (w_busy & (w_wait_nx == TW'(TIMEOUT)));
        end
    end

    assign MemTimeout = r_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .q     (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .q     (FlushCount)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench for two instances (LU_STALL=1 and LU_STALL=2) on shared inputs.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, mr, urb, xmr, xmw, rdy, br;
    logic [4:0] rw, ra, rb;

    wire [4:0]  a_ctl, b_ctl;
    wire        a_to, b_to;
    wire [15:0] a_sc, a_fc, b_sc, b_fc;

    hazard_stall_unit #(.LU_STALL(1)) dut_a (
        .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_Rw(rw), .IF_ID_Ra(ra), .IF_ID_Rb(rb),
        .IF_ID_UsesRb(urb), .EX_MEM_MemRead(xmr), .EX_MEM_MemWrite(xmw), .MemReady(rdy), .BrTaken(br),
        .PCWrite(a_ctl[4]), .IF_ID_Write(a_ctl[3]), .IF_ID_Flush(a_ctl[2]), .ID_EX_Bubble(a_ctl[1]),
        .Pipe_Freeze(a_ctl[0]), .MemTimeout(a_to), .StallCycles(a_sc), .FlushCount(a_fc)
    );

    hazard_stall_unit #(.LU_STALL(2)) dut_b (
        .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_Rw(rw), .IF_ID_Ra(ra), .IF_ID_Rb(rb),
        .IF_ID_UsesRb(urb), .EX_MEM_MemRead(xmr), .EX_MEM_MemWrite(xmw), .MemReady(rdy), .BrTaken(br),
        .PCWrite(b_ctl[4]), .IF_ID_Write(b_ctl[3]), .IF_ID_Flush(b_ctl[2]), .ID_EX_Bubble(b_ctl[1]),
        .Pipe_Freeze(b_ctl[0]), .MemTimeout(b_to), .StallCycles(b_sc), .FlushCount(b_fc)
    );

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}
    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_STL = 5'b00010;
    localparam logic [4:0] C_FRZ = 5'b00001;
    localparam logic [4:0] C_BR  = 5'b11110;
    localparam logic [4:0] C_RST = 5'b00110;

    typedef struct {
        bit          sel;
        logic [4:0]  ctl;
        logic        to;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string n, input logic [15:0] got, input logic [15:0] want_v);
        checks++;
        if (got !== want_v) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, got, want_v, $time);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
                cmp("b_ctl", {11'd0, b_ctl}, {11'd0, e.ctl});
                cmp("b_timeout", {15'd0, b_to}, {15'd0, e.to});
                cmp("b_stallcycles", b_sc, e.sc);
                cmp("b_flushcount", b_fc, e.fc);
            end else begin
                cmp("a_ctl", {11'd0, a_ctl}, {11'd0, e.ctl});
                cmp("a_timeout", {15'd0, a_to}, {15'd0, e.to});
                cmp("a_stallcycles", a_sc, e.sc);
                cmp("a_flushcount", a_fc, e.fc);
            end
        end
    end

    task automatic drive(input logic r, m, input logic [4:0] w, a, b,
                         input logic u, xr, xw, rd, bt);
        @(posedge clk);
        #1;
        reset = r; mr = m; rw = w; ra = a; rb = b;
        urb = u; xmr = xr; xmw = xw; rdy = rd; br = bt;
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic mem_wait();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic want(input bit s, input logic [4:0] c, input logic t,
                        input logic [15:0] sc, input logic [15:0] fc);
        q.push_back('{s, c, t, sc, fc});
    endtask

    initial begin
        idle(1'b1);
        idle(1'b1); want(0, C_RST, 0, 0, 0); want(1, C_RST, 0, 0, 0);
        idle(1'b0); want(0, C_RUN, 0, 0, 0); want(1, C_RUN, 0, 0, 0);

        // single load-use bubble, Ra match
        idle(1'b1);
        drive(0, 1, 5'd1, 5'd1, 5'd0, 0, 0, 0, 1, 0); want(0, C_STL, 0, 0, 0);
        idle(1'b0); want(0, C_RUN, 0, 1, 0);

        // r0 never hazards; Rb ignored when unused
        idle(1'b1);
        drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0); want(0, C_RUN, 0, 0, 0);
        drive(0, 1, 5'd2, 5'd0, 5'd2, 0, 0, 0, 1, 0); want(0, C_RUN, 0, 0, 0);
        idle(1'b0); want(0, C_RUN, 0, 0, 0);

        // two bubbles via Rb with LU_STALL=2
        idle(1'b1);
        drive(0, 1, 5'd3, 5'd0, 5'd3, 1, 0, 0, 1, 0); want(1, C_STL, 0, 0, 0);
        drive(0, 1, 5'd3, 5'd0, 5'd3, 1, 0, 0, 1, 0); want(1, C_STL, 0, 1, 0);
        idle(1'b0); want(1, C_RUN, 0, 2, 0);

        // memory wait in the middle of LU_STALL
        idle(1'b1);
        drive(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 1, 0); want(1, C_STL, 0, 0, 0);
        repeat (3) begin
            mem_wait(); want(1, C_FRZ, 0, 1, 0);
        end
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0); want(1, C_STL, 0, 1, 0);
        idle(1'b0); want(1, C_RUN, 0, 2, 0);

        // branch overrides a load-use hazard
        idle(1'b1);
        drive(0, 1, 5'd1, 5'd1, 5'd0, 0, 0, 0, 1, 1); want(0, C_BR, 0, 0, 0); want(1, C_BR, 0, 0, 0);
        idle(1'b0); want(0, C_RUN, 0, 0, 1); want(1, C_RUN, 0, 0, 1);

        // busy outranks branch
        idle(1'b1);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1); want(0, C_FRZ, 0, 0, 0);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1); want(0, C_BR, 0, 0, 0);
        idle(1'b0); want(0, C_RUN, 0, 0, 1);

        // reset mid-stall returns to RUN
        idle(1'b1);
        drive(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 1, 0); want(1, C_STL, 0, 0, 0);
        idle(1'b1); want(1, C_RST, 0, 1, 0);
        idle(1'b0); want(1, C_RUN, 0, 0, 0);

        // memory timeout at exactly TIMEOUT busy cycles, sticky until reset
        idle(1'b1);
        repeat (255) begin
            mem_wait(); want(0, C_FRZ, 0, 0, 0);
        end
        mem_wait(); want(0, C_FRZ, 1, 0, 0); want(1, C_FRZ, 1, 0, 0);
        idle(1'b0); want(0, C_RUN, 1, 0, 0);
        idle(1'b1); want(0, C_RST, 1, 0, 0);
        idle(1'b0); want(0, C_RUN, 0, 0, 0); want(1, C_RUN, 0, 0, 0);

        idle(1'b0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
